commit_unit: RTL and testbench

//  Parametrised N-wide in-order commit stage of the OoO core. Retires up to NR_COMMIT

---
 rtl/commit_unit.sv | 208 ++++++++++++++++++++
 tb/tb_commit_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit_pkg / commit_unit
//
// In-order commit stage for the out-of-order core. Each cycle it retires up to
// NR_COMMIT finished instructions from the scoreboard head (slot 0 = oldest),
// acknowledges them combinationally so the scoreboard can pop them, and writes
// their results to the GPR file one cycle later. CSR instructions are
// serialised through a three-state FSM (IDLE -> CSR_ISSUE -> CSR_WB). The FSM
// strobes the CSR file once and writes the old CSR value back to rd.
//
// Optional feature: define COMMIT_PERF_EN to add commit_cnt_o, a 64-bit
// counter of retired instructions.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush_i           pipeline flush
//   instr_valid_i     per slot: slot holds a finished instruction
//   instr_rd_i        per slot: destination register
//   instr_result_i    per slot: result (CSR instr: CSR write operand)
//   instr_is_csr_i    per slot: instruction is a CSR access
//   instr_csr_op_i    per slot: CSR operation
//   commit_ack_o      per slot: retired this cycle (combinational)
//   gpr_we_o          per slot: GPR write enable (registered)
//   gpr_waddr_o       per slot: GPR write address (registered)
//   gpr_wdata_o       per slot: GPR write data (registered)
//   csr_req_o         one-cycle CSR access strobe
//   csr_op_o          CSR operation, ADD when idle
//   csr_wdata_o       CSR write operand, 0 when idle
//   csr_rdata_i       old CSR value, valid the cycle after csr_req_o
//   commit_cnt_o      (COMMIT_PERF_EN only) total retired instructions
// -----------------------------------------------------------------------------
package commit_unit_pkg;
  typedef enum logic [1:0] {
    ADD       = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } fu_op_t;
endpackage

module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int NR_COMMIT  = 2,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic [NR_COMMIT-1:0]               instr_valid_i,
  input  logic [NR_COMMIT*REG_ADDR_W-1:0]    instr_rd_i,
  input  logic [NR_COMMIT*XLEN-1:0]          instr_result_i,
  input  logic [NR_COMMIT-1:0]               instr_is_csr_i,
  input  logic [NR_COMMIT*$bits(fu_op_t)-1:0] instr_csr_op_i,
  output logic [NR_COMMIT-1:0]               commit_ack_o,
  output logic [NR_COMMIT-1:0]               gpr_we_o,
  output logic [NR_COMMIT*REG_ADDR_W-1:0]    gpr_waddr_o,
  output logic [NR_COMMIT*XLEN-1:0]          gpr_wdata_o,
  output logic                               csr_req_o,
  output fu_op_t                             csr_op_o,
  output logic [XLEN-1:0]                    csr_wdata_o,
  input  logic [XLEN-1:0]                    csr_rdata_i
`ifdef COMMIT_PERF_EN
  ,
  output logic [63:0]                        commit_cnt_o
`endif
);

  localparam int OP_W = $bits(fu_op_t);

  typedef enum logic [1:0] {
    IDLE,
    CSR_ISSUE,
    CSR_WB
  } state_t;

  state_t                 state_q, state_d;
  logic [REG_ADDR_W-1:0]  csr_rd_q;
  fu_op_t                 csr_op_q;
  logic [XLEN-1:0]        csr_operand_q;
  logic [NR_COMMIT-1:0]   ack;
  logic [NR_COMMIT-1:0]   shadowed;
  logic                   csr_start;
  logic                   blocked;
  logic                   csr_active;

  // Only the slot-0 CSR op is ever latched; CSRs in younger slots wait
  // until they reach slot 0.
  logic unused_csr_ops;
  assign unused_csr_ops = ^instr_csr_op_i[NR_COMMIT*OP_W-1:OP_W];

  // Next-state and retirement decision. In IDLE the oldest contiguous run of
  // finished non-CSR instructions retires; the first empty or CSR slot blocks
  // itself and everything younger. A CSR in slot 0 starts the CSR sequence.
  // CSR_WB retires the CSR itself and cannot be flushed, because the CSR side
  // effect has already happened.
  always_comb begin
    state_d   = state_q;
    ack       = '0;
    csr_start = 1'b0;
    blocked   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush_i) begin
          for (int i = 0; i < NR_COMMIT; i++) begin
            if (!blocked && instr_valid_i[i] && !instr_is_csr_i[i]) ack[i] = 1'b1;
            else                                                    blocked = 1'b1;
          end
          if (instr_valid_i[0] && instr_is_csr_i[0]) begin
            state_d   = CSR_ISSUE;
            csr_start = 1'b1;
          end
        end
      end
      CSR_ISSUE: state_d = flush_i ? IDLE : CSR_WB;
      CSR_WB: begin
        ack[0]  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) ack = '0;
  end

  // When several retiring slots target the same register, only the youngest
  // write survives, so older slots are masked here.
  always_comb begin
    shadowed = '0;
    for (int i = 0; i < NR_COMMIT; i++) begin
      for (int j = i + 1; j < NR_COMMIT; j++) begin
        if (ack[j] &&
            instr_rd_i[j*REG_ADDR_W +: REG_ADDR_W] == instr_rd_i[i*REG_ADDR_W +: REG_ADDR_W])
          shadowed[i] = 1'b1;
      end
    end
  end

  // The CSR strobe is high only during CSR_ISSUE. A flush in that same cycle
  // suppresses it, so an aborted CSR never touches the CSR file.
  assign csr_active   = (state_q == CSR_ISSUE) && !flush_i && !rst;
  assign csr_req_o    = csr_active;
  assign csr_op_o     = csr_active ? csr_op_q : ADD;
  assign csr_wdata_o  = csr_active ? csr_operand_q : '0;
  assign commit_ack_o = ack;

  // FSM state plus the CSR instruction's fields, latched on entry so the
  // sequence does not depend on the slot inputs afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      csr_rd_q      <= '0;
      csr_op_q      <= ADD;
      csr_operand_q <= '0;
    end else begin
      state_q <= state_d;
      if (csr_start) begin
        csr_rd_q      <= instr_rd_i[REG_ADDR_W-1:0];
        csr_op_q      <= fu_op_t'(instr_csr_op_i[OP_W-1:0]);
        csr_operand_q <= instr_result_i[XLEN-1:0];
      end
    end
  end

  // GPR write register stage. Retired slots write one cycle later, and x0 is
  // never written. In CSR_WB, slot 0 carries the old CSR value to the latched rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_we_o    <= '0;
      gpr_waddr_o <= '0;
      gpr_wdata_o <= '0;
    end else begin
      for (int i = 0; i < NR_COMMIT; i++) begin
        gpr_we_o[i] <= ack[i] && (instr_rd_i[i*REG_ADDR_W +: REG_ADDR_W] != '0) && !shadowed[i];
        if (ack[i]) begin
          gpr_waddr_o[i*REG_ADDR_W +: REG_ADDR_W] <= instr_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
          gpr_wdata_o[i*XLEN +: XLEN]             <= instr_result_i[i*XLEN +: XLEN];
        end
      end
      if (state_q == CSR_WB) begin
        gpr_we_o[0]                  <= (csr_rd_q != '0);
        gpr_waddr_o[REG_ADDR_W-1:0]  <= csr_rd_q;
        gpr_wdata_o[XLEN-1:0]        <= csr_rdata_i;
      end
    end
  end

`ifdef COMMIT_PERF_EN
  logic [63:0] commit_cnt_q;
  logic [63:0] ack_count;

  // Popcount of this cycle's retirements.
  always_comb begin
    ack_count = '0;
    for (int i = 0; i < NR_COMMIT; i++) ack_count = ack_count + 64'(ack[i]);
  end

  // Free-running retirement counter. It wraps naturally and a flush does not
  // clear it.
  always_ff @(posedge clk) begin
    if (rst) commit_cnt_q <= '0;
    else     commit_cnt_q <= commit_cnt_q + ack_count;
  end

  assign commit_cnt_o = commit_cnt_q;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_commit_unit
//
// Self-checking bench for commit_unit. A behavioural model tracks the
// scoreboard as a queue of instructions, with a done flag per entry. Each
// cycle it predicts the acks, the CSR strobe and the registered GPR writes.
// Directed sequences pin the model with literal values, and a randomized run
// with flushes and resets follows. Define COMMIT_PERF_EN to also check the
// retirement counter.
// -----------------------------------------------------------------------------
module tb_commit_unit;
  import commit_unit_pkg::*;

  localparam int NC = 2;
  localparam int XL = 32;
  localparam int RW = 5;
  localparam int OW = $bits(fu_op_t);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic [NC-1:0]     instr_valid_i;
  logic [NC*RW-1:0]  instr_rd_i;
  logic [NC*XL-1:0]  instr_result_i;
  logic [NC-1:0]     instr_is_csr_i;
  logic [NC*OW-1:0]  instr_csr_op_i;
  logic [NC-1:0]     commit_ack_o;
  logic [NC-1:0]     gpr_we_o;
  logic [NC*RW-1:0]  gpr_waddr_o;
  logic [NC*XL-1:0]  gpr_wdata_o;
  logic              csr_req_o;
  fu_op_t            csr_op_o;
  logic [XL-1:0]     csr_wdata_o;
  logic [XL-1:0]     csr_rdata_i;
`ifdef COMMIT_PERF_EN
  logic [63:0]       commit_cnt_o;
`endif

  always #5 clk = ~clk;

  commit_unit #(.NR_COMMIT(NC), .XLEN(XL), .REG_ADDR_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .instr_valid_i  (instr_valid_i),
    .instr_rd_i     (instr_rd_i),
    .instr_result_i (instr_result_i),
    .instr_is_csr_i (instr_is_csr_i),
    .instr_csr_op_i (instr_csr_op_i),
    .commit_ack_o   (commit_ack_o),
    .gpr_we_o       (gpr_we_o),
    .gpr_waddr_o    (gpr_waddr_o),
    .gpr_wdata_o    (gpr_wdata_o),
    .csr_req_o      (csr_req_o),
    .csr_op_o       (csr_op_o),
    .csr_wdata_o    (csr_wdata_o),
    .csr_rdata_i    (csr_rdata_i)
`ifdef COMMIT_PERF_EN
    ,
    .commit_cnt_o   (commit_cnt_o)
`endif
  );

  typedef struct {
    logic [RW-1:0] rd;
    logic [XL-1:0] res;
    bit            is_csr;
    fu_op_t        op;
    bit            done;
  } instr_t;

  int checks = 0;
  int errors = 0;

  // Scoreboard model: csr_phase counts how far the current CSR has progressed
  // (0 none, 1 strobe cycle, 2 writeback cycle).
  instr_t          q[$];
  int              csr_phase = 0;
  instr_t          csr_lat;
  logic [XL-1:0]   next_rdata = '0;
  bit              cur_flush, cur_rst;
  logic [NC-1:0]   m_ack;
  bit              m_req;
  fu_op_t          m_op;
  logic [XL-1:0]   m_cwd;
  logic [NC-1:0]   m_we = '0;
  logic [RW-1:0]   m_addr[NC];
  logic [XL-1:0]   m_data[NC];
  longint unsigned m_cnt = 0;

  // Values sampled mid-cycle, reused by the literal checks.
  logic [NC-1:0]   s_ack, s_we;
  logic            s_req;
  fu_op_t          s_op;
  logic [XL-1:0]   s_cwd;
  logic [RW-1:0]   s_addr[NC];
  logic [XL-1:0]   s_data[NC];
  logic [63:0]     s_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [RW-1:0] rd, input logic [XL-1:0] res,
                                input bit is_csr, input fu_op_t op, input bit done);
    instr_t t;
    t.rd = rd; t.res = res; t.is_csr = is_csr; t.op = op; t.done = done;
    return t;
  endfunction

  task automatic applyStimulus(input bit fl, input bit rs, input bit fill);
    int k;
    @(negedge clk);
    if (fill) begin
      while (q.size() < 4)
        q.push_back(mk(RW'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0),
                       fu_op_t'(2'($urandom_range(1, 3))), 1'b0));
      for (int i = 0; i < NC; i++) begin
        if (!q[i].done && $urandom_range(0, 2) != 0) begin
          instr_t t = q[i];
          t.done = 1'b1;
          q[i] = t;
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (i < q.size()) begin
        instr_valid_i[i]            = q[i].done;
        instr_rd_i[i*RW +: RW]      = q[i].rd;
        instr_result_i[i*XL +: XL]  = q[i].res;
        instr_is_csr_i[i]           = q[i].is_csr;
        instr_csr_op_i[i*OW +: OW]  = q[i].op;
      end else begin
        instr_valid_i[i]            = 1'b0;
        instr_rd_i[i*RW +: RW]      = RW'($urandom);
        instr_result_i[i*XL +: XL]  = $urandom;
        instr_is_csr_i[i]           = 1'($urandom);
        instr_csr_op_i[i*OW +: OW]  = OW'($urandom);
      end
    end
    flush_i     = fl;
    rst         = rs;
    csr_rdata_i = next_rdata;
    cur_flush   = fl;
    cur_rst     = rs;
    m_ack = '0; m_req = 1'b0; m_op = ADD; m_cwd = '0;
    if (!rs) begin
      if (csr_phase == 0 && !fl) begin
        k = 0;
        while (k < NC && k < q.size() && q[k].done && !q[k].is_csr) k++;
        m_ack = NC'((1 << k) - 1);
      end else if (csr_phase == 1 && !fl) begin
        m_req = 1'b1; m_op = csr_lat.op; m_cwd = csr_lat.res;
      end else if (csr_phase == 2) begin
        m_ack = NC'(1);
      end
    end
  endtask

  task automatic checkOutput();
    #1;
    s_ack = commit_ack_o; s_we = gpr_we_o; s_req = csr_req_o;
    s_op = csr_op_o; s_cwd = csr_wdata_o;
    for (int i = 0; i < NC; i++) begin
      s_addr[i] = gpr_waddr_o[i*RW +: RW];
      s_data[i] = gpr_wdata_o[i*XL +: XL];
    end
    check("ack", s_ack, m_ack);
    check("csr_req", s_req, m_req);
    check("csr_op", s_op, m_op);
    check("csr_wdata", s_cwd, m_cwd);
    check("gpr_we", s_we, m_we);
    for (int i = 0; i < NC; i++) begin
      if (m_we[i]) begin
        check("gpr_waddr", s_addr[i], m_addr[i]);
        check("gpr_wdata", s_data[i], m_data[i]);
      end
    end
`ifdef COMMIT_PERF_EN
    s_cnt = commit_cnt_o;
    check("commit_cnt", s_cnt, m_cnt);
`endif
  endtask

  task automatic advanceModel();
    bit            seen[2**RW];
    logic [NC-1:0] new_we;
    int            popped;
    int            nxt;
    if (cur_rst) begin
      q.delete();
      csr_phase = 0; m_we = '0; m_cnt = 0;
      for (int i = 0; i < NC; i++) begin m_addr[i] = '0; m_data[i] = '0; end
      return;
    end
    new_we = '0;
    for (int r = 0; r < 2**RW; r++) seen[r] = 1'b0;
    if (csr_phase == 2) begin
      new_we[0] = (csr_lat.rd != 0); m_addr[0] = csr_lat.rd; m_data[0] = next_rdata;
    end else begin
      for (int i = NC - 1; i >= 0; i--) begin
        if (m_ack[i]) begin
          m_addr[i] = q[i].rd; m_data[i] = q[i].res;
          new_we[i] = (q[i].rd != 0) && !seen[q[i].rd];
          seen[q[i].rd] = 1'b1;
        end
      end
    end
    m_we = new_we;
    popped = $countones(m_ack);
    m_cnt += longint'(popped);
    nxt = 0;
    if (csr_phase == 0) begin
      if (!cur_flush && q.size() > 0 && q[0].done && q[0].is_csr) begin
        csr_lat = q[0]; nxt = 1;
      end
    end else if (csr_phase == 1) begin
      nxt = cur_flush ? 0 : 2;
    end
    csr_phase = nxt;
    for (int i = 0; i < popped; i++) void'(q.pop_front());
    if (cur_flush) q.delete();
  endtask

  task automatic runCycle(input bit fl, input bit rs, input bit fill, input bit do_check);
    applyStimulus(fl, rs, fill);
    if (do_check) checkOutput();
    @(posedge clk);
    advanceModel();
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; instr_valid_i = '0; instr_rd_i = '0;
    instr_result_i = '0; instr_is_csr_i = '0; instr_csr_op_i = '0; csr_rdata_i = '0;
    for (int i = 0; i < NC; i++) begin m_addr[i] = '0; m_data[i] = '0; end

    runCycle(0, 1, 0, 0);
    runCycle(0, 1, 0, 0);

    // Reset state
    runCycle(0, 0, 0, 1);
    check("rst_ack", s_ack, 2'b00);
    check("rst_we", s_we, 2'b00);
    check("rst_req", s_req, 1'b0);
    check("rst_op", s_op, ADD);
    check("rst_addr0", s_addr[0], 5'd0);

    // Two ALU instrs retire together, writes one cycle later
    q.push_back(mk(5'd3, 32'h11, 0, ADD, 1));
    q.push_back(mk(5'd4, 32'h22, 0, ADD, 1));
    runCycle(0, 0, 0, 1);
    check("t1_ack", s_ack, 2'b11);
    runCycle(0, 0, 0, 1);
    check("t1_we", s_we, 2'b11);
    check("t1_addr1", s_addr[1], 5'd4);
    check("t1_data0", s_data[0], 32'h11);

    // Empty slot 0 blocks retirement of slot 1
    q.push_back(mk(5'd1, 32'h1, 0, ADD, 0));
    q.push_back(mk(5'd2, 32'h2, 0, ADD, 1));
    runCycle(0, 0, 0, 1);
    check("t2_ack", s_ack, 2'b00);
    runCycle(0, 0, 0, 1);
    check("t2_we", s_we, 2'b00);
    check("t2_req", s_req, 1'b0);
    q.delete();

    // ALU then CSR: ALU retires, CSR strobes, then writes back the old value
    q.push_back(mk(5'd5, 32'h55, 0, ADD, 1));
    q.push_back(mk(5'd6, 32'h8, 1, CSR_SET, 1));
    runCycle(0, 0, 0, 1);
    check("t3_ack_alu", s_ack, 2'b01);
    runCycle(0, 0, 0, 1);
    check("t3_ack_idle", s_ack, 2'b00);
    runCycle(0, 0, 0, 1);
    check("t3_req", s_req, 1'b1);
    check("t3_op", s_op, CSR_SET);
    check("t3_cwd", s_cwd, 32'h8);
    next_rdata = 32'hDEAD;
    runCycle(0, 0, 0, 1);
    check("t3_ack_wb", s_ack, 2'b01);
    runCycle(0, 0, 0, 1);
    check("t3_we", s_we, 2'b01);
    check("t3_addr", s_addr[0], 5'd6);
    check("t3_data", s_data[0], 32'hDEAD);

    // Same rd in both slots: youngest wins
    q.push_back(mk(5'd7, 32'hA, 0, ADD, 1));
    q.push_back(mk(5'd7, 32'hB, 0, ADD, 1));
    runCycle(0, 0, 0, 1);
    check("t4_ack", s_ack, 2'b11);
    runCycle(0, 0, 0, 1);
    check("t4_we", s_we, 2'b10);
    check("t4_data1", s_data[1], 32'hB);

    // rd=0 retires without a write; flush during CSR_ISSUE aborts the CSR
    q.push_back(mk(5'd0, 32'h99, 0, ADD, 1));
    runCycle(0, 0, 0, 1);
    check("t5_ack", s_ack, 2'b01);
    q.push_back(mk(5'd9, 32'h3, 1, CSR_WRITE, 1));
    runCycle(0, 0, 0, 1);
    check("t5_we0", s_we, 2'b00);
    runCycle(1, 0, 0, 1);
    check("t5_flush_req", s_req, 1'b0);
    check("t5_flush_ack", s_ack, 2'b00);
    runCycle(0, 0, 0, 1);
    check("t5_after_req", s_req, 1'b0);

    // Reset during CSR_WB
    q.push_back(mk(5'd10, 32'h4, 1, CSR_CLEAR, 1));
    runCycle(0, 0, 0, 1);
    runCycle(0, 0, 0, 1);
    next_rdata = 32'hBEEF;
    runCycle(0, 1, 0, 1);
    check("t6_rst_ack", s_ack, 2'b00);
    runCycle(0, 0, 0, 1);
    check("t6_we", s_we, 2'b00);
    check("t6_req", s_req, 1'b0);
    check("t6_op", s_op, ADD);
    check("t6_cwd", s_cwd, 32'h0);
    check("t6_data0", s_data[0], 32'h0);
`ifdef COMMIT_PERF_EN
    check("t6_cnt0", s_cnt, 64'd0);
    for (int i = 0; i < 6; i++) q.push_back(mk(5'(11 + i), 32'(i), 0, ADD, 1));
    for (int i = 0; i < 3; i++) runCycle(0, 0, 0, 1);
    runCycle(0, 0, 0, 1);
    check("t6_cnt6", s_cnt, 64'd6);
`endif

    // Randomized traffic with occasional flushes and resets
    for (int n = 0; n < 3000; n++) begin
      next_rdata = $urandom;
      runCycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0), 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
